// File: rtl/sar_scan_ctrl.sv
// sar_scan_ctrl: multi-channel conversion sequencer for the 8-bit SAR ADC core.
// Scans the enabled channels in ascending order, drives the analog mux select,
// waits for the mux to settle, fires a one-cycle cnvst, captures the result on
// eoc and offers it on a valid/ready port.
// Optional build macro: SAR_AVG4_EN (four back-to-back conversions per channel,
// averaged by truncating the RES+2 bit sum).
module sar_scan_ctrl #(
    parameter int NCH        = 4,
    parameter int CHW        = 2,
    parameter int RES        = 8,
    parameter int SETTLE_CYC = 3,
    parameter int TIMEOUT    = 31
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_scan_start,
    input  logic           i_cont,
    input  logic           i_abort,
    input  logic [NCH-1:0] i_ch_mask,
    output logic           o_cnvst,
    input  logic           i_eoc,
    input  logic [RES-1:0] i_sar,
    output logic [CHW-1:0] o_ch_sel,
    output logic [RES-1:0] o_res_data,
    output logic [CHW-1:0] o_res_ch,
    output logic           o_res_valid,
    input  logic           i_res_ready,
    output logic           o_busy,
    output logic           o_scan_done,
    output logic           o_timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_CONV   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_OUT    = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      SETTLE_LIM = 4'(SETTLE_CYC);
    localparam logic [TW-1:0]   TO_LOAD    = TW'(TIMEOUT);
    localparam logic [TW-1:0]   TO_LAST    = TW'(1);

    logic [2:0]     r_state;
    logic [3:0]     r_settle_cnt;
    logic [TW-1:0]  r_tcnt;
    logic [NCH-1:0] r_mask;
    logic [CHW-1:0] r_ch_sel;
    logic [RES-1:0] r_res_data;
    logic [CHW-1:0] r_res_ch;
    logic           r_res_valid;
    logic           r_busy;
    logic           r_scan_done;
    logic           r_timeout_err;
    logic           r_cnvst;

    logic [CHW-1:0] w_start_idx;
    logic [CHW-1:0] w_wrap_idx;
    logic [CHW-1:0] w_next_idx;
    logic           w_next_found;

`ifdef SAR_AVG4_EN
    logic [RES+1:0] r_acc;
    logic [1:0]     r_sample;
    logic [RES+1:0] w_acc_sum;

    // Running sum including the sample arriving this cycle
    always_comb begin
        w_acc_sum = r_acc + {2'b00, i_sar};
    end
`endif

    // Channel pickers: lowest bit of the incoming mask, lowest bit of the latched
    // mask (wrap in continuous mode), and next latched bit above the current channel
    always_comb begin
        w_start_idx  = '0;
        w_wrap_idx   = '0;
        w_next_idx   = '0;
        w_next_found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i_ch_mask[i]) begin
                w_start_idx = CHW'(i);
            end
            if (r_mask[i]) begin
                w_wrap_idx = CHW'(i);
            end
            if (r_mask[i] && (i > int'(r_ch_sel))) begin
                w_next_idx   = CHW'(i);
                w_next_found = 1'b1;
            end
        end
    end

    // Scan sequencer; abort outranks eoc and the result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_settle_cnt  <= '0;
            r_tcnt        <= '0;
            r_mask        <= '0;
            r_ch_sel      <= '0;
            r_res_data    <= '0;
            r_res_ch      <= '0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_scan_done   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnvst       <= 1'b0;
`ifdef SAR_AVG4_EN
            r_acc         <= '0;
            r_sample      <= '0;
`endif
        end else begin
            r_cnvst     <= 1'b0;
            r_scan_done <= 1'b0;
            if (i_abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_res_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_scan_start && (|i_ch_mask)) begin
                            r_mask        <= i_ch_mask;
                            r_ch_sel      <= w_start_idx;
                            r_busy        <= 1'b1;
                            r_timeout_err <= 1'b0;
                            r_settle_cnt  <= '0;
                            r_state       <= S_SETTLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == SETTLE_LIM) begin
                            r_cnvst <= 1'b1;
                            r_state <= S_CONV;
`ifdef SAR_AVG4_EN
                            r_acc    <= '0;
                            r_sample <= '0;
`endif
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 4'd1;
                        end
                    end
                    S_CONV: begin
                        r_tcnt  <= TO_LOAD;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (i_eoc) begin
`ifdef SAR_AVG4_EN
                            if (r_sample == 2'd3) begin
                                r_res_data  <= w_acc_sum[RES+1:2];
                                r_res_ch    <= r_ch_sel;
                                r_res_valid <= 1'b1;
                                r_state     <= S_OUT;
                            end else begin
                                r_acc    <= w_acc_sum;
                                r_sample <= r_sample + 2'd1;
                                r_cnvst  <= 1'b1;
                                r_state  <= S_CONV;
                            end
`else
                            r_res_data  <= i_sar;
                            r_res_ch    <= r_ch_sel;
                            r_res_valid <= 1'b1;
                            r_state     <= S_OUT;
`endif
                        end else if (r_tcnt == TO_LAST) begin
                            r_timeout_err <= 1'b1;
                            r_state       <= S_NEXT;
                        end else begin
                            r_tcnt <= r_tcnt - TO_LAST;
                        end
                    end
                    S_OUT: begin
                        if (i_res_ready) begin
                            r_res_valid <= 1'b0;
                            r_state     <= S_NEXT;
                        end
                    end
                    S_NEXT: begin
                        if (w_next_found) begin
                            r_ch_sel     <= w_next_idx;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end else if (i_cont) begin
                            r_ch_sel     <= w_wrap_idx;
                            r_settle_cnt <= '0;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_busy      <= 1'b0;
                            r_scan_done <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_cnvst       = r_cnvst;
    assign o_ch_sel      = r_ch_sel;
    assign o_res_data    = r_res_data;
    assign o_res_ch      = r_res_ch;
    assign o_res_valid   = r_res_valid;
    assign o_busy        = r_busy;
    assign o_scan_done   = r_scan_done;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: doc/sar_scan_ctrl.md
Name: sar_scan_ctrl

Overview:
Multi-channel conversion sequencer for the 8-bit SAR ADC core. It scans an enabled channel set in ascending order and drives the analog input mux select. For each channel it waits a mux settle time, issues a one-cycle cnvst, captures the result on eoc, and presents it on a valid/ready output port. It sits between the system register/DMA side and the SAR logic block, and it owns all cnvst generation.

Parameters:
NCH, 4, number of analog channels (2..16)
CHW, 2, channel index width, equal to clog2(NCH)
RES, 8, conversion result width; must match the SAR core output
SETTLE_CYC, 3, mux settle cycles between ch_sel change and cnvst (1..15)
TIMEOUT, 31, max cycles from cnvst to eoc before abandoning the channel (>= 16)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous reset, active-low; asserted when 0, released synchronously to clk by the upstream reset synchroniser
scan_start  in  1  request one scan; sampled only in IDLE
cont  in  1  continuous mode; when 1, scan wraps to the first channel instead of ending
abort  in  1  synchronous abort of an active scan
ch_mask  in  NCH  enabled channels; latched on the accepted scan_start
cnvst  out  1  convert start to the SAR core; one-cycle pulse
eoc  in  1  end of conversion from the SAR core; sar is valid in the same cycle
sar  in  RES  conversion result from the SAR core
ch_sel  out  CHW  analog mux select
res_data  out  RES  captured result
res_ch  out  CHW  channel index of res_data
res_valid  out  1  result available
res_ready  in  1  consumer accepts the result
busy  out  1  scan in progress
scan_done  out  1  one-cycle pulse when a non-continuous scan completes
timeout_err  out  1  sticky; set on an eoc timeout, cleared on the next accepted scan_start

Behaviour:
- Reset (rst=0): state IDLE; all outputs 0; latched mask 0; all counters 0.
- States: IDLE, SETTLE, CONV, WAIT, OUT, NEXT.
- IDLE, scan_start=1 and ch_mask!=0: latch the mask; ch_sel <= lowest set bit; busy <= 1; clear timeout_err; go to SETTLE. If ch_mask=0, the request is ignored, busy stays 0, and no scan_done is issued.
- SETTLE: hold for SETTLE_CYC cycles, then go to CONV. cnvst is high exactly SETTLE_CYC+1 cycles after the edge that accepted scan_start.
- CONV: cnvst=1 for exactly one cycle; load the timeout counter; go to WAIT.
- WAIT: on eoc=1, capture sar into res_data and ch_sel into res_ch; res_valid=1 from the next cycle; go to OUT.
  - If TIMEOUT cycles elapse without eoc, set timeout_err, produce no result, and go to NEXT.
- eoc in any state other than WAIT is ignored.
- OUT: hold res_valid, res_data and res_ch stable until res_valid&&res_ready. In the transfer cycle, drop res_valid on the next edge and go to NEXT. res_ready while res_valid=0 has no effect.
- NEXT: select the next set mask bit above the current ch_sel.
  - If one exists: update ch_sel and go to SETTLE.
  - If none and cont=1: select the lowest set bit and go to SETTLE.
  - If none and cont=0: busy <= 0, scan_done pulses 1 cycle, go to IDLE.
- A single-channel mask with cont=1 reconverts the same channel repeatedly, with a full SETTLE each time.
- cont is sampled only in NEXT.
- abort=1 in any non-IDLE state goes to IDLE on the next edge: busy=0, res_valid=0, cnvst=0, no scan_done. Any pending result is discarded. abort has priority over eoc and over the res handshake.
- scan_start while busy is ignored. ch_mask changes while busy have no effect.
- Reset mid-conversion behaves as abort and additionally clears timeout_err.
- ch_sel holds its last value in IDLE.

Optional Feature:
SAR_AVG4_EN
- Defined: each channel is converted 4 times back-to-back, with SETTLE applied only before the first conversion. The samples are summed into a RES+2 bit accumulator, and res_data = sum[RES+1:2] (truncated). A timeout on any of the 4 samples abandons that channel and produces no result.
- Undefined: one conversion per channel and no accumulator logic.

Test Plan:
- ch_mask=4'b1011, cont=0, eoc returned 10 cycles after each cnvst with sar=8'h11/8'h22/8'h44, res_ready=1 -> results in ch order 0,1,3 with res_data 11/22/44; scan_done pulses once; busy falls the same cycle.
- scan_start at edge k, SETTLE_CYC=3 -> cnvst high in exactly one cycle at k+4; ch_sel stable for 3 cycles before it.
- res_ready held 0 for 20 cycles after res_valid -> res_data/res_ch unchanged; no second cnvst until the transfer completes.
- eoc never returned on ch1, mask=4'b0011 -> timeout_err=1 after 31 cycles; ch0 result delivered, no ch1 result, scan_done pulses.
- cont=1, mask=4'b0100 -> repeated ch2 conversions; abort mid-WAIT -> IDLE next cycle, busy=0, res_valid=0, no scan_done.
- rst=0 asynchronously during OUT -> all outputs 0 immediately; after release, scan_start with ch_mask=0 -> no activity.
